// File: rtl/booth_mult_unit.sv
// booth_mult_unit: sequential radix-2 Booth signed multiplier, one iteration per clock, start/stop handshake.
// Define BOOTH_MULT_ZERO_SHORTCUT_EN to complete zero-operand multiplies on the start edge.
module booth_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mult_in,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             mult_out,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH:0] acc, m, sum, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic q_m1;
    logic [CW-1:0] count;
    logic start, last, zero;

    assign start = mult_in && state != RUN;
    assign last = state == RUN && count == CW'(1);
    assign mult_out = state == DONE;
    assign busy = state == RUN;
`ifdef BOOTH_MULT_ZERO_SHORTCUT_EN
    assign zero = A == '0 || B == '0;
`else
    assign zero = 1'b0;
`endif

    // acc is one bit wider than the operands so acc - m cannot overflow for m = -2^(WIDTH-1)
    always_comb begin
        sum = {q[0], q_m1} == 2'b01 ? acc + m : {q[0], q_m1} == 2'b10 ? acc - m : acc;
        acc_n = {sum[WIDTH], sum[WIDTH:1]};
        q_n = {sum[0], q[WIDTH-1:1]};
        state_n = state == RUN ? (last ? DONE : RUN) : start ? (zero ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            m <= '0;
            q <= '0;
            q_m1 <= 1'b0;
            count <= '0;
            HI <= '0;
            LO <= '0;
        end else if (start) begin
            m <= {A[WIDTH-1], A};
            q <= B;
            acc <= '0;
            q_m1 <= 1'b0;
            count <= CW'(WIDTH);
            if (zero) begin
                HI <= '0;
                LO <= '0;
            end
        end else if (state == RUN) begin
            acc <= acc_n;
            q <= q_n;
            q_m1 <= q[0];
            count <= count - 1'b1;
            if (last) begin
                HI <= acc_n[WIDTH-1:0];
                LO <= q_n;
            end
        end
    end
endmodule
